// File: rtl/req_pending_latch.sv
// Request edge detector and sticky pending latch that feeds p_encoder and issues one grant at a time.
// Optional build macro REQ_LOST_COUNT_EN adds a saturating counter of edges that hit an already-pending line.
module req_pending_latch #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] reqIn,
    input  logic [WIDTH-1:0] reqMask,
    output logic [WIDTH-1:0] pendingVec,
    input  logic [IDX_W-1:0] encIndex,
    output logic             grantValid,
    output logic [IDX_W-1:0] grantIndex,
    input  logic             ack,
    output logic [7:0]       lostCount
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] reqPrev;
    logic [WIDTH-1:0] reqEdge;
    logic [WIDTH-1:0] clr;
    logic             ackTaken;

    assign reqEdge    = reqIn & ~reqPrev;
    assign pendingVec = pending & reqMask;
    assign ackTaken   = (state == GRANT) && ack;

    // NOTE: clr is given a default before the conditional write so no latch is inferred.
    always_comb begin
        clr = '0;
        if (ackTaken) begin
            clr[grantIndex] = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // Edge is OR-ed in after the clear, so a same-cycle re-request keeps the bit pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqPrev <= '0;
            pending <= '0;
        end else begin
            reqPrev <= reqIn;
            pending <= (pending & ~clr) | reqEdge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grantValid <= 1'b0;
            grantIndex <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pendingVec) begin
                        grantIndex <= encIndex;
                        grantValid <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        grantValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    grantValid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_LOST_COUNT_EN
    logic lostHit;

    // An edge on a line already pending (masked or being acked) is a lost request.
    assign lostHit = |(reqEdge & pending);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lostCount <= 8'h00;
        end else if (lostHit && (lostCount != 8'hFF)) begin
            lostCount <= lostCount + 8'd1;
        end
    end
`else
    assign lostCount = 8'h00;
`endif

endmodule

// File: tb/tb_req_pending_latch.sv
// Self-checking bench for req_pending_latch: table-driven vectors plus hand sequences for reset and held lines.
// Build with REQ_LOST_COUNT_EN defined to also check the lost-request counter.
module tb_req_pending_latch;

    logic       clk;
    logic       reset;
    logic [7:0] reqIn;
    logic [7:0] reqMask;
    logic [7:0] pendingVec;
    logic [2:0] encIndex;
    logic       grantValid;
    logic [2:0] grantIndex;
    logic       ack;
    logic [7:0] lostCount;

    int nChecks = 0;
    int nPass   = 0;

`ifdef REQ_LOST_COUNT_EN
    localparam logic [7:0] LOST1 = 8'd1;
`else
    localparam logic [7:0] LOST1 = 8'd0;
`endif

    req_pending_latch #(.WIDTH(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .reqIn      (reqIn),
        .reqMask    (reqMask),
        .pendingVec (pendingVec),
        .encIndex   (encIndex),
        .grantValid (grantValid),
        .grantIndex (grantIndex),
        .ack        (ack),
        .lostCount  (lostCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority encoder model: highest set bit wins.
    always_comb begin
        encIndex = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pendingVec[i]) encIndex = i[2:0];
        end
    end

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic [7:0] expPv;
        logic       expGv;
        logic [2:0] expGi;
        logic [7:0] expLost;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a);
        @(negedge clk);
        reqIn   = r;
        reqMask = m;
        ack     = a;
        @(posedge clk);
        #1;
    endtask

    int  grants;
    logic prevGv;

    initial begin
        // req, mask, ack | pendingVec, grantValid, grantIndex, lostCount
        // 1: single pulse on line 2
        vecs.push_back('{8'h04, 8'hFF, 1'b0, 8'h04, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h04, 1'b1, 3'd2, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0});
        // 2: lines 7 and 0 together, highest first, one idle cycle between grants
        vecs.push_back('{8'h81, 8'hFF, 1'b0, 8'h81, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h81, 1'b1, 3'd7, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0});
        // 3: line 5 held pending while masked, granted once unmasked
        vecs.push_back('{8'h20, 8'hDF, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hDF, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hDF, 1'b0, 8'h00, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h20, 1'b1, 3'd5, 8'd0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 3'd5, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0});
        // 4: ack and re-request of line 3 in the same cycle, set wins
        vecs.push_back('{8'h08, 8'hFF, 1'b0, 8'h08, 1'b0, 3'd0, 8'd0});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h08, 1'b1, 3'd3, 8'd0});
        vecs.push_back('{8'h08, 8'hFF, 1'b1, 8'h08, 1'b0, 3'd0, LOST1});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h08, 1'b1, 3'd3, LOST1});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, LOST1});

        reset   = 1'b1;
        reqIn   = 8'h00;
        reqMask = 8'hFF;
        ack     = 1'b0;
        #12;
        check("rst_pv", pendingVec, 8'h00);
        check("rst_gv", grantValid, 1'b0);
        check("rst_gi", grantIndex, 3'd0);
        check("rst_lost", lostCount, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].ack);
            check($sformatf("v%0d_pv", i), pendingVec, vecs[i].expPv);
            check($sformatf("v%0d_gv", i), grantValid, vecs[i].expGv);
            if (vecs[i].expGv) check($sformatf("v%0d_gi", i), grantIndex, vecs[i].expGi);
            check($sformatf("v%0d_lost", i), lostCount, vecs[i].expLost);
        end

        // 5: reset mid-grant clears everything without a clock edge
        step(8'h40, 8'hFF, 1'b0);
        step(8'h00, 8'hFF, 1'b0);
        check("r5_gv_pre", grantValid, 1'b1);
        check("r5_gi_pre", grantIndex, 3'd6);
        #2;
        reset = 1'b1;
        #1;
        check("r5_gv", grantValid, 1'b0);
        check("r5_pv", pendingVec, 8'h00);
        check("r5_lost", lostCount, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(8'h00, 8'hFF, 1'b0);
        check("r5_gv_after", grantValid, 1'b0);

        // 6: held-high line makes exactly one grant
        grants = 0;
        prevGv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(8'h02, 8'hFF, grantValid);
            if (grantValid && !prevGv) grants++;
            prevGv = grantValid;
        end
        check("h6_grants", grants, 1);
        check("h6_pv", pendingVec, 8'h00);
        step(8'h00, 8'hFF, 1'b0);
        step(8'h02, 8'hFF, 1'b0);
        for (int c = 0; c < 5 && !grantValid; c++) step(8'h02, 8'hFF, 1'b0);
        check("h6_regrant_gv", grantValid, 1'b1);
        check("h6_regrant_gi", grantIndex, 3'd1);
        step(8'h02, 8'hFF, 1'b1);
        check("h6_end_gv", grantValid, 1'b0);
        check("h6_end_pv", pendingVec, 8'h00);
        check("h6_lost", lostCount, 8'h00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
